// File: rtl/axis_ggx_theta.sv
// ============================================================================
// Module   : axis_ggx_theta
// Purpose  : Maps packed Sobol samples (u1,u2) to GGX cos^2(theta) and phi.
//            Build option: GGX_THETA_OVERLAP_EN lets OUT accept the next sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_ggx_theta #(
  parameter int FRAC_BITS  = 32,
  parameter int ALPHA_BITS = 16
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_areset,
  input  logic [ALPHA_BITS-1:0]     alpha2,
  input  logic                      s00_axis_tvalid,
  output logic                      s00_axis_tready,
  input  logic [2*FRAC_BITS-1:0]    s00_axis_tdata,
  input  logic [2*FRAC_BITS/8-1:0]  s00_axis_tstrb,
  input  logic                      s00_axis_tlast,
  output logic                      m00_axis_tvalid,
  input  logic                      m00_axis_tready,
  output logic [2*FRAC_BITS-1:0]    m00_axis_tdata,
  output logic [2*FRAC_BITS/8-1:0]  m00_axis_tstrb,
  output logic                      m00_axis_tlast
);

  localparam int CNT_W = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_s_tready;
  logic   w_m_tvalid;
  logic   w_accept;

  logic [FRAC_BITS-1:0]  r_u1;
  logic [FRAC_BITS-1:0]  r_u2;
  logic [ALPHA_BITS-1:0] r_alpha;
  logic                  r_last;

  logic [FRAC_BITS:0]    r_num;
  logic [FRAC_BITS:0]    r_den;
  logic                  r_sat;
  logic [FRAC_BITS+1:0]  r_rem;
  logic [FRAC_BITS-1:0]  r_quo;
  logic [CNT_W-1:0]      r_cnt;

  logic [FRAC_BITS-1:0]  r_cos;
  logic [FRAC_BITS-1:0]  r_phi;
  logic                  r_olast;

  logic [ALPHA_BITS+FRAC_BITS-1:0] w_prod;
  logic [FRAC_BITS:0]    w_num;
  logic [FRAC_BITS:0]    w_p;
  logic [FRAC_BITS:0]    w_den;
  logic [FRAC_BITS+1:0]  w_sh;
  logic [FRAC_BITS+1:0]  w_den_ext;
  logic                  w_ge;
  logic [FRAC_BITS+1:0]  w_rem_nxt;
  logic [FRAC_BITS-1:0]  w_quo_nxt;
  logic                  w_unused;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_tready  = 1'b0;
    w_m_tvalid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_s_tready = 1'b1;
        if (s00_axis_tvalid) w_state_nxt = S_MUL;
      end
      S_MUL: w_state_nxt = S_DIV;
      S_DIV: if (r_cnt == '0) w_state_nxt = S_OUT;
      S_OUT: begin
        w_m_tvalid = 1'b1;
`ifdef GGX_THETA_OVERLAP_EN
        w_s_tready = m00_axis_tready;
        if (m00_axis_tready) w_state_nxt = s00_axis_tvalid ? S_MUL : S_IDLE;
`else
        if (m00_axis_tready) w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Held low while reset is asserted so nothing is accepted during reset.
  assign s00_axis_tready = w_s_tready && !s00_axis_areset;
  assign w_accept        = s00_axis_tvalid && s00_axis_tready;

  assign w_prod = {{FRAC_BITS{1'b0}}, r_alpha} * {{ALPHA_BITS{1'b0}}, r_u1};
  assign w_num  = {1'b1, {FRAC_BITS{1'b0}}} - {1'b0, r_u1};
  assign w_p    = w_prod[ALPHA_BITS-1 +: FRAC_BITS+1];
  assign w_den  = w_num + w_p;

  // Restoring division step: remainder stays below den, so F+2 bits suffice.
  assign w_sh      = {r_rem[FRAC_BITS:0], 1'b0};
  assign w_den_ext = {1'b0, r_den};
  assign w_ge      = (w_sh >= w_den_ext);
  assign w_rem_nxt = w_ge ? (w_sh - w_den_ext) : w_sh;
  assign w_quo_nxt = {r_quo[FRAC_BITS-2:0], w_ge};

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_u1    <= '0;
      r_u2    <= '0;
      r_alpha <= '0;
      r_last  <= 1'b0;
      r_num   <= '0;
      r_den   <= '0;
      r_sat   <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_cos   <= '0;
      r_phi   <= '0;
      r_olast <= 1'b0;
    end else begin
      if (w_accept) begin
        r_u1    <= s00_axis_tdata[FRAC_BITS-1:0];
        r_u2    <= s00_axis_tdata[2*FRAC_BITS-1:FRAC_BITS];
        r_alpha <= alpha2;
        r_last  <= s00_axis_tlast;
      end
      case (r_state)
        S_MUL: begin
          r_num <= w_num;
          r_den <= w_den;
          r_sat <= (w_num == w_den);
          r_rem <= {1'b0, w_num};
          r_cnt <= CNT_W'(FRAC_BITS - 1);
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          // Output registers only change here, so they hold steady in OUT.
          if (r_cnt == '0) begin
            r_cos   <= r_sat ? {FRAC_BITS{1'b1}} : w_quo_nxt;
            r_phi   <= r_u2;
            r_olast <= r_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign m00_axis_tvalid = w_m_tvalid;
  assign m00_axis_tdata  = {r_phi, r_cos};
  assign m00_axis_tlast  = r_olast;
  assign m00_axis_tstrb  = '1;

  assign w_unused = ^{s00_axis_tstrb, w_prod[ALPHA_BITS-2:0], r_rem[FRAC_BITS+1], r_num};

endmodule

`default_nettype wire
